bnn_weight_streamer: RTL and testbench

- Transmit side of the BNN weight-load interface. The host writes one weight byte per neuron into a local buffer, then requests a load.
- The block replays the buffer as the nibble stream the BNN core consumes: 4-bit nibble plus load-enable, low nibble first, two cycles per neuron.
- It sits between the host/config logic and the core's uio_in[7:4] (nibble) and uio_in[3] (load_en) pins, and produces a cycle-exact, gap-aware stream.

---
 rtl/bnn_pkg.sv | 23 ++
 rtl/bnn_weight_streamer_if.sv | 14 +
 rtl/bnn_weight_buf.sv | 48 ++++
 rtl/bnn_weight_streamer.sv | 139 +++++++++++++
 tb/tb_bnn_weight_streamer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/bnn_pkg.sv
// Constants shared with the BNN core plus the stream FSM state type.
package bnn_pkg;
  localparam int NUM_NEURONS = 12;
  localparam int WEIGHT_W    = 8;
  localparam int NIB_W       = 4;
  localparam int PTR_W       = 5;

  localparam int NUM_NIBS  = 2 * NUM_NEURONS;
  localparam int PAD_NIBS  = (2 ** PTR_W - NUM_NEURONS) * 2;
  localparam int CNT_W     = $clog2(NUM_NEURONS + 1);
  localparam int NIB_IDX_W = $clog2(NUM_NIBS);
  localparam int PAD_W     = $clog2(PAD_NIBS);

  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(NUM_NEURONS);
  localparam logic [NIB_IDX_W-1:0] NIB_LAST = NIB_IDX_W'(NUM_NIBS - 1);
  localparam logic [PAD_W-1:0]     PAD_LAST = PAD_W'(PAD_NIBS - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    PAD
  } stream_state_e;
endpackage

// File: rtl/bnn_weight_streamer_if.sv
// Host write port of the weight streamer.
interface bnn_weight_streamer_if;
  import bnn_pkg::*;

  logic                wr_valid;
  logic                wr_ready;
  logic [WEIGHT_W-1:0] wr_data;

  // A byte transfers on every rising clk edge where wr_valid && wr_ready;
  // wr_data must be stable while wr_valid is high, and the master may not
  // wait for wr_ready before raising wr_valid.
  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/bnn_weight_buf.sv
// Weight register file: sequential write by fill count, nibble-granular read.
module bnn_weight_buf
  import bnn_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [WEIGHT_W-1:0]  wr_data,
  input  logic                 clr,
  input  logic [NIB_IDX_W-1:0] rd_idx,
  output logic [NIB_W-1:0]     rd_nibble,
  output logic [CNT_W-1:0]     count
);
  logic [WEIGHT_W-1:0]  mem_q [NUM_NEURONS];
  logic [WEIGHT_W-1:0]  mem_d [NUM_NEURONS];
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     rd_neuron;
  logic [WEIGHT_W-1:0]  rd_word;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (wr_en && (count_q < CNT_FULL)) begin
      mem_d[count_q] = wr_data;
      count_d        = count_q + CNT_W'(1);
    end
  end

  // Indices past the last neuron only occur on the prefetch after the final nibble.
  always_comb begin
    rd_neuron = rd_idx[NIB_IDX_W-1:1];
    rd_word   = (rd_neuron < CNT_FULL) ? mem_q[rd_neuron] : '0;
    rd_nibble = rd_idx[0] ? rd_word[WEIGHT_W-1:NIB_W] : rd_word[NIB_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
endmodule

// File: rtl/bnn_weight_streamer.sv
// Replays buffered weight bytes to the BNN core as a low-nibble-first stream.
// Define BNN_STREAM_WRAP_EN to append zero pad nibbles that wrap the core pointer to 0.
module bnn_weight_streamer
  import bnn_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  bnn_weight_streamer_if.slave  wr,
  input  logic                  start,
  input  logic                  tgt_ena,
  output logic                  load_en,
  output logic [NIB_W-1:0]      load_nibble,
  output logic                  busy,
  output logic                  done,
  output logic                  start_err,
  output stream_state_e         state_dbg
);
  stream_state_e        state_q, state_d;
  logic [NIB_IDX_W-1:0] idx_q, idx_d;
  logic [PAD_W-1:0]     pad_q, pad_d;
  logic                 load_en_q, load_en_d;
  logic [NIB_W-1:0]     nib_q, nib_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 wr_en, buf_clr;
  logic [NIB_IDX_W-1:0] rd_idx;
  logic [NIB_W-1:0]     rd_nibble;
  logic [CNT_W-1:0]     count;

  // Holding wr_ready low during the done cycle keeps it rising one cycle later.
  assign wr.wr_ready = (state_q == IDLE) && !done_q && (count < CNT_FULL);
  assign wr_en       = wr.wr_valid && wr.wr_ready;
  assign rd_idx      = (state_q == STREAM) ? idx_q + NIB_IDX_W'(1) : '0;

  bnn_weight_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr.wr_data),
    .clr       (buf_clr),
    .rd_idx    (rd_idx),
    .rd_nibble (rd_nibble),
    .count     (count)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pad_d     = pad_q;
    load_en_d = load_en_q;
    nib_d     = nib_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    buf_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count == CNT_FULL) begin
            state_d   = STREAM;
            idx_d     = '0;
            load_en_d = 1'b1;
            nib_d     = rd_nibble;
            busy_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (load_en_q && tgt_ena) begin
          if (idx_q == NIB_LAST) begin
`ifdef BNN_STREAM_WRAP_EN
            state_d = PAD;
            pad_d   = '0;
            nib_d   = '0;
`else
            state_d   = IDLE;
            load_en_d = 1'b0;
            nib_d     = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            buf_clr   = 1'b1;
`endif
          end else begin
            idx_d = idx_q + NIB_IDX_W'(1);
            nib_d = rd_nibble;
          end
        end
      end
      PAD: begin
        if (load_en_q && tgt_ena) begin
          if (pad_q == PAD_LAST) begin
            state_d   = IDLE;
            load_en_d = 1'b0;
            nib_d     = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            buf_clr   = 1'b1;
          end else begin
            pad_d = pad_q + PAD_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pad_q     <= '0;
      load_en_q <= 1'b0;
      nib_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pad_q     <= pad_d;
      load_en_q <= load_en_d;
      nib_q     <= nib_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign load_en     = load_en_q;
  assign load_nibble = nib_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign start_err   = err_q;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Directed bench for bnn_weight_streamer with a behavioural BNN core receiver.
module tb_bnn_weight_streamer;
  import bnn_pkg::*;

  logic          clk = 1'b0;
  logic          reset, start, tgt_ena, core_rst;
  logic          load_en, busy, done, start_err;
  logic [3:0]    load_nibble;
  stream_state_e state_dbg;

  bnn_weight_streamer_if wr_if ();

  bnn_weight_streamer dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr_if.slave),
    .start       (start),
    .tgt_ena     (tgt_ena),
    .load_en     (load_en),
    .load_nibble (load_nibble),
    .busy        (busy),
    .done        (done),
    .start_err   (start_err),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

`ifdef BNN_STREAM_WRAP_EN
  localparam int PAD_CYC = 40;
  localparam int END_PTR = 0;
`else
  localparam int PAD_CYC = 0;
  localparam int END_PTR = 12;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: consumes a nibble whenever load_en and ena are both high.
  logic [7:0] core_w [32];
  logic [4:0] core_ptr;
  logic       core_half;
  always @(posedge clk) begin
    if (core_rst) begin
      core_ptr  <= '0;
      core_half <= 1'b0;
    end else if (tgt_ena && load_en) begin
      if (!core_half) core_w[core_ptr][3:0] <= load_nibble;
      else            core_w[core_ptr][7:4] <= load_nibble;
      core_half <= ~core_half;
      if (core_half) core_ptr <= core_ptr + 5'd1;
    end
  end

  logic [7:0] img [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr1(input int idx, input logic [7:0] v);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = v;
    img[idx]       = v;
    tick();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) wr1(k, base + 8'(k));
  endtask

  task automatic core_reset();
    core_rst = 1'b1;
    tick();
    core_rst = 1'b0;
  endtask

  task automatic run_stream(input int hold_at, input int hold_len, input bit wv_hold);
    int         s_pre;
    logic [7:0] b;
    logic [3:0] e;
    s_pre = cyc;
    start = 1'b1;
    if (wv_hold) begin
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = 8'hEE;
    end
    tick();
    start = 1'b0;
    chk("state_stream", state_dbg, STREAM);
    for (int i = 0; i < 24; i++) begin
      b = img[i / 2];
      e = (i % 2 == 1) ? b[7:4] : b[3:0];
      chk("stream_load_en", load_en, 1);
      chk("stream_nibble", load_nibble, e);
      chk("stream_busy", busy, 1);
      chk("stream_wr_ready", wr_if.wr_ready, 0);
      if (i == hold_at) begin
        tgt_ena = 1'b0;
        repeat (hold_len) begin
          tick();
          chk("hold_load_en", load_en, 1);
          chk("hold_nibble", load_nibble, e);
        end
        tgt_ena = 1'b1;
      end
      tick();
    end
`ifdef BNN_STREAM_WRAP_EN
    for (int p = 0; p < 40; p++) begin
      chk("pad_load_en", load_en, 1);
      chk("pad_nibble", load_nibble, 0);
      chk("pad_done", done, 0);
      tick();
    end
`endif
    wr_if.wr_valid = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_load_en", load_en, 0);
    chk("done_nibble", load_nibble, 0);
    chk("done_wr_ready", wr_if.wr_ready, 0);
    chk("done_latency", cyc - s_pre, 25 + hold_len + PAD_CYC);
    tick();
    chk("after_done", done, 0);
    chk("after_wr_ready", wr_if.wr_ready, 1);
    chk("core_ptr", core_ptr, END_PTR);
    chk("core_half", core_half, 0);
    for (int n = 0; n < 12; n++) chk("core_weight", core_w[n], img[n]);
  endtask

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    tgt_ena        = 1'b1;
    core_rst       = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;
    repeat (2) tick();
    chk("rst_wr_ready", wr_if.wr_ready, 1);
    chk("rst_load_en", load_en, 0);
    chk("rst_nibble", load_nibble, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_start_err", start_err, 0);
    chk("rst_state", state_dbg, IDLE);
    reset = 1'b0;

    // Full image 0x10..0x1B at full rate.
    core_reset();
    fill(12, 8'h10);
    chk("full_wr_ready", wr_if.wr_ready, 0);
    run_stream(-1, 0, 1'b0);

    // Start with 11th byte written in the same cycle is rejected.
    fill(10, 8'h20);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 8'h2A;
    img[10]        = 8'h2A;
    start          = 1'b1;
    tick();
    start          = 1'b0;
    wr_if.wr_valid = 1'b0;
    chk("rej_start_err", start_err, 1);
    chk("rej_load_en", load_en, 0);
    chk("rej_busy", busy, 0);
    chk("rej_wr_ready", wr_if.wr_ready, 1);
    tick();
    chk("rej_err_clear", start_err, 0);
    chk("rej_load_en2", load_en, 0);
    wr1(11, 8'hAA);
    chk("aa_wr_ready", wr_if.wr_ready, 0);
    core_reset();
    run_stream(7, 3, 1'b0);

    // Reset while nibble 10 is on the bus.
    core_reset();
    fill(12, 8'h30);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("mid_nibble10", load_nibble, 4'h5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_load_en", load_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_ready", wr_if.wr_ready, 1);
    chk("mid_rst_nibble", load_nibble, 0);
    chk("mid_rst_state", state_dbg, IDLE);
    fill(11, 8'h40);
    chk("refill11_wr_ready", wr_if.wr_ready, 1);
    wr1(11, 8'h4B);
    chk("refill12_wr_ready", wr_if.wr_ready, 0);
    core_reset();
    run_stream(-1, 0, 1'b1);

    // After a stream with wr_valid held, the next byte lands in buf[0].
    core_reset();
    fill(12, 8'h50);
    run_stream(-1, 0, 1'b0);
    chk("buf0_after_done", core_w[0], 8'h50);

`ifdef BNN_STREAM_WRAP_EN
    // Back-to-back loads with no core reset in between.
    fill(12, 8'h60);
    run_stream(-1, 0, 1'b0);
    fill(12, 8'h70);
    run_stream(-1, 0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
